ifu_fill_responder: RTL and testbench
=====================================

IFU_FILL_RESPONDER -- requirements
Module: ifu_fill_responder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter: MEM_LINES, 256, backing-store depth in 128-bit lines.
REQ-003 Parameter: WORDS_PER_LINE, 4, 32-bit words per line (LINE_WIDTH/32).
REQ-004 Port: Clk  in  1  clock; all state changes on rising edge.
REQ-005 Port: Rst  in  1  asynchronous active-high reset.
REQ-006 Port: FillReqValid  in  1  IFU fill request valid.
REQ-007 Port: FillReqAddr  in  28  line address (PC[31:4]).
REQ-008 Port: FillReqReady  out  1  responder can accept a request.
REQ-009 Port: FillRspValid  out  1  response line valid.
REQ-010 Port: FillRspAddr  out  28  echo of the accepted line address.
REQ-011 Port: FillRspData  out  128  line data; word0 in [31:0], word3 in [127:96].
REQ-012 Port: FillRspErr  out  1  accepted address was out of range.
REQ-013 Port: FillRspReady  in  1  IFU accepts the response.
REQ-014 Port: MemWrEn  in  1  backdoor word write enable (loader).
REQ-015 Port: MemWrAddr  in  32  word-aligned byte address of the write; bits [1:0] ignored.
REQ-016 Port: MemWrData  in  32  write data.

Function
REQ-017 FSM states: IDLE, READ, RESP.
REQ-018 FillReqReady SHALL be 1 only in IDLE; a request is accepted in the cycle where FillReqValid&&FillReqReady.
REQ-019 On acceptance with FillReqAddr<MEM_LINES: latch the address, clear the word counter, and go to READ.
REQ-020 On acceptance with FillReqAddr>=MEM_LINES: go directly to RESP next cycle with FillRspErr=1 and FillRspData=0.
REQ-021 READ: issue word reads 0..3 on consecutive cycles.
REQ-022 The memory read latency SHALL be one cycle; each returned word is placed in its line slot.
REQ-023 The 2-bit word counter SHALL not wrap; READ exits after word3 data is captured.
REQ-024 For an in-range request accepted in cycle T, FillRspValid SHALL be 1 in cycle T+6.
REQ-025 For an out-of-range request accepted in cycle T, FillRspValid SHALL be 1 in cycle T+1.
REQ-026 RESP: FillRspValid=1; Addr, Data and Err SHALL remain stable until FillRspValid&&FillRspReady.
REQ-027 RESP exit: when FillRspValid&&FillRspReady, return to IDLE next cycle; FillReqReady=1 in that cycle.
REQ-028 FillRspReady held at 1 SHALL NOT shorten latency; handshake minimum is one cycle in RESP.
REQ-029 Writes SHALL be accepted in any state; a write to a word already read does not alter the in-flight line.
REQ-030 A write and a read of the same word in the same cycle SHALL return the old data (read-before-write).
REQ-031 Writes with MemWrAddr[31:2] >= MEM_LINES*4 SHALL be dropped silently.
REQ-032 FillRspValid SHALL be 0 in IDLE and READ.
REQ-033 FillReqValid is ignored in READ and RESP; no queuing, at most one request outstanding.

Reset
REQ-034 Rst asserted, including mid-READ or mid-RESP, SHALL force IDLE immediately.
REQ-035 Rst SHALL force FillReqReady=0 while asserted, then 1 in the first cycle after deassertion.
REQ-036 Rst SHALL force FillRspValid=0, FillRspErr=0, FillRspData=0, FillRspAddr=0 and the counter to 0.
REQ-037 Reset SHALL NOT clear memory contents; a request aborted by reset produces no response.

Structure
REQ-038 ifu_pkg SHALL add: WORD_WIDTH=32, WORDS_PER_LINE=LINE_WIDTH/WORD_WIDTH, LINE_ADDR_WIDTH=28.
REQ-039 ifu_pkg SHALL add the state enum t_fill_state and packed structs t_fill_req {addr} and t_fill_rsp {addr, data, err}; the line type is data_arr_t.
REQ-040 The backing store SHALL be sub-module ifu_fill_mem: 32-bit x MEM_LINES*4 words, one synchronous read port, one write port.

Verification
REQ-041 Preload line 0x5 with words 0x11111111, 0x22222222, 0x33333333, 0x44444444; request addr 0x5 at T with RspReady=1 -> RspValid at T+6, Data=0x44444444_33333333_22222222_11111111, Err=0, Addr=0x5.
REQ-042 Request addr 0x100 (MEM_LINES=256) at T -> RspValid at T+1, Err=1, Data=0, no memory reads issued.
REQ-043 Hold RspReady=0 for 10 cycles after RspValid -> Data/Addr stable all 10 cycles; ReqReady=0 throughout; release -> ReqReady=1 next cycle.
REQ-044 During READ of line 0x2, write 0xDEADBEEF to word3 (byte addr 0x2C) in the same cycle word3 is read -> response word3 is old value; a repeat request returns 0xDEADBEEF.
REQ-045 Assert Rst at T+3 of a request -> RspValid never rises; after deassert, ReqReady=1 and a new request to 0x5 returns the REQ-041 data.
REQ-046 Back-to-back requests 0x1, 0x2 with FillReqValid held high -> two responses in order, second accepted the cycle after the first response handshake.

Source files
------------

// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifu_pkg
// Purpose  : Shared types and constants for the IFU line-fill responder.
//            Line geometry, fill FSM state type, request/response structs.
// Revision : 1.0 - initial release
// ============================================================================
package ifu_pkg;

  localparam int LINE_WIDTH      = 128;
  localparam int WORD_WIDTH      = 32;
  localparam int WORDS_PER_LINE  = LINE_WIDTH / WORD_WIDTH;
  localparam int LINE_ADDR_WIDTH = 28;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_RESP = 2'd2
  } t_fill_state;

  // word0 sits in the least-significant slot
  typedef logic [WORDS_PER_LINE-1:0][WORD_WIDTH-1:0] data_arr_t;

  typedef struct packed {
    logic [LINE_ADDR_WIDTH-1:0] addr;
  } t_fill_req;

  typedef struct packed {
    logic [LINE_ADDR_WIDTH-1:0] addr;
    data_arr_t                  data;
    logic                       err;
  } t_fill_rsp;

endpackage
`default_nettype wire

// File: rtl/ifu_fill_mem.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fill_mem
// Purpose  : Word-wide backing store for the fill responder. One synchronous
//            read port (one-cycle latency) and one write port. A read and a
//            write to the same word in one cycle return the old data.
// Ports    : clk        - clock
//            i_rd_en    - read enable
//            i_rd_addr  - word index to read
//            o_rd_data  - read data, valid the cycle after i_rd_en
//            i_wr_en    - write enable
//            i_wr_addr  - word index to write
//            i_wr_data  - write data
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fill_mem
  import ifu_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_rd_en,
  input  logic [ADDR_W-1:0]     i_rd_addr,
  output logic [WORD_WIDTH-1:0] o_rd_data,
  input  logic                  i_wr_en,
  input  logic [ADDR_W-1:0]     i_wr_addr,
  input  logic [WORD_WIDTH-1:0] i_wr_data
);

  logic [WORD_WIDTH-1:0] r_mem [DEPTH];

  // Both updates are non-blocking, so a same-word read samples the
  // pre-write contents. No reset: contents survive Rst.
  always_ff @(posedge clk) begin
    if (i_rd_en) begin
      o_rd_data <= r_mem[i_rd_addr];
    end
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ifu_fill_responder.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fill_responder
// Purpose  : Services IFU line-fill requests from a local word memory.
//            An in-range request reads words 0..3 on consecutive cycles and
//            presents the assembled line; an out-of-range request answers
//            immediately with FillRspErr set and zero data. One request is
//            outstanding at a time. A backdoor port loads the memory.
// Ports    : Clk, Rst                  - clock, async active-high reset
//            FillReqValid/Addr/Ready   - line request handshake
//            FillRspValid/Addr/Data/Err, FillRspReady - response handshake
//            MemWrEn/Addr/Data         - backdoor word write (byte address)
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fill_responder #(
  parameter int MEM_LINES      = 256,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         FillReqValid,
  input  logic [27:0]  FillReqAddr,
  output logic         FillReqReady,
  output logic         FillRspValid,
  output logic [27:0]  FillRspAddr,
  output logic [127:0] FillRspData,
  output logic         FillRspErr,
  input  logic         FillRspReady,
  input  logic         MemWrEn,
  input  logic [31:0]  MemWrAddr,
  input  logic [31:0]  MemWrData
);

  import ifu_pkg::*;

  localparam int         c_words      = MEM_LINES * WORDS_PER_LINE;
  localparam int         c_word_idx_w = $clog2(c_words);
  localparam int         c_line_idx_w = $clog2(MEM_LINES);
  localparam logic [1:0] c_last_word  = 2'(WORDS_PER_LINE - 1);

  t_fill_state r_state;
  t_fill_rsp   r_rsp;
  t_fill_req   w_req;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [1:0]  r_cnt;         // next word to issue
  logic        r_issue_done;  // all words issued; counter parks at last word
  logic        r_cap_pend;    // a read was issued last cycle
  logic [1:0]  r_cap_idx;     // slot for the returning word

  logic                    w_req_in_range;
  logic                    w_rd_en;
  logic [c_word_idx_w-1:0] w_rd_addr;
  logic [WORD_WIDTH-1:0]   w_rd_data;
  logic                    w_wr_en;
  logic [c_word_idx_w-1:0] w_wr_addr;
  logic                    w_unused;

  assign w_req.addr     = FillReqAddr;
  assign w_req_in_range = (w_req.addr < 28'(MEM_LINES));

  assign w_rd_en   = (r_state == S_READ) && !r_issue_done;
  assign w_rd_addr = c_word_idx_w'({r_rsp.addr[c_line_idx_w-1:0], r_cnt});

  // Writes beyond the store are dropped rather than aliased.
  assign w_wr_en   = MemWrEn && (MemWrAddr[31:2] < 30'(c_words));
  assign w_wr_addr = MemWrAddr[c_word_idx_w+1:2];
  assign w_unused  = ^MemWrAddr[1:0];

  ifu_fill_mem #(
    .DEPTH  (c_words),
    .ADDR_W (c_word_idx_w)
  ) u_mem (
    .clk       (Clk),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (MemWrData)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp        <= '0;
      r_cnt        <= 2'd0;
      r_issue_done <= 1'b0;
      r_cap_pend   <= 1'b0;
      r_cap_idx    <= 2'd0;
    end else begin
      r_cap_pend <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Ready comes up one cycle after reset release.
          r_req_ready <= 1'b1;
          if (FillReqValid && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_rsp.addr  <= w_req.addr;
            r_rsp.data  <= '0;
            if (w_req_in_range) begin
              r_state      <= S_READ;
              r_rsp.err    <= 1'b0;
              r_cnt        <= 2'd0;
              r_issue_done <= 1'b0;
            end else begin
              r_state     <= S_RESP;
              r_rsp.err   <= 1'b1;
              r_rsp_valid <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (!r_issue_done) begin
            r_cap_pend <= 1'b1;
            r_cap_idx  <= r_cnt;
            if (r_cnt == c_last_word) begin
              r_issue_done <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 2'd1;
            end
          end
          // Capture lags issue by one cycle; leave once the last word lands.
          if (r_cap_pend) begin
            r_rsp.data[r_cap_idx] <= w_rd_data;
            if (r_cap_idx == c_last_word) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
            end
          end
        end
        S_RESP: begin
          if (FillRspReady) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign FillReqReady = r_req_ready;
  assign FillRspValid = r_rsp_valid;
  assign FillRspAddr  = r_rsp.addr;
  assign FillRspData  = r_rsp.data;
  assign FillRspErr   = r_rsp.err;

endmodule
`default_nettype wire

// File: tb/tb_ifu_fill_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_fill_responder
// Purpose  : Self-checking bench for ifu_fill_responder. A timeline model of
//            request/response events and a word-array image of the memory
//            predict every output each cycle; directed scenarios add explicit
//            value and latency checks, followed by randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifu_fill_responder;

  logic         Clk;
  logic         Rst;
  logic         FillReqValid;
  logic [27:0]  FillReqAddr;
  logic         FillReqReady;
  logic         FillRspValid;
  logic [27:0]  FillRspAddr;
  logic [127:0] FillRspData;
  logic         FillRspErr;
  logic         FillRspReady;
  logic         MemWrEn;
  logic [31:0]  MemWrAddr;
  logic [31:0]  MemWrData;

  ifu_fill_responder #(
    .MEM_LINES      (256),
    .WORDS_PER_LINE (4)
  ) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .FillReqValid (FillReqValid),
    .FillReqAddr  (FillReqAddr),
    .FillReqReady (FillReqReady),
    .FillRspValid (FillRspValid),
    .FillRspAddr  (FillRspAddr),
    .FillRspData  (FillRspData),
    .FillRspErr   (FillRspErr),
    .FillRspReady (FillRspReady),
    .MemWrEn      (MemWrEn),
    .MemWrAddr    (MemWrAddr),
    .MemWrData    (MemWrData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- reference model state ----------------
  logic [31:0]      mem_model [1024];
  logic             m_busy;
  logic             m_err;
  logic [27:0]      m_addr;
  logic [3:0][31:0] m_data;
  int               m_t;
  int               m_rsp_cycle;
  int               m_ready_from;
  int               cyc;
  int               n_chk;
  int               n_err;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Check this cycle's outputs, advance the model over the coming edge,
  // then move to 1 time unit after that edge.
  task automatic step();
    logic exp_v;
    logic exp_r;
    exp_v = m_busy && (cyc >= m_rsp_cycle);
    exp_r = !m_busy && (cyc >= m_ready_from) && !Rst;
    check("req_ready", FillReqReady, exp_r);
    check("rsp_valid", FillRspValid, exp_v);
    if (exp_v) begin
      check("rsp_addr", FillRspAddr, m_addr);
      check("rsp_data", FillRspData, m_data);
      check("rsp_err", FillRspErr, m_err);
    end
    if (!Rst) begin
      // word k of an in-range line is read in cycle accept+1+k
      if (m_busy && !m_err) begin
        for (int k = 0; k < 4; k++) begin
          if (cyc == m_t + 1 + k) m_data[k] = mem_model[int'(m_addr) * 4 + k];
        end
      end
      if (exp_r && FillReqValid) begin
        m_busy = 1'b1;
        m_t    = cyc;
        m_addr = FillReqAddr;
        m_data = '0;
        if (FillReqAddr < 28'd256) begin
          m_err       = 1'b0;
          m_rsp_cycle = cyc + 6;
        end else begin
          m_err       = 1'b1;
          m_rsp_cycle = cyc + 1;
        end
      end else if (exp_v && FillRspReady) begin
        m_busy       = 1'b0;
        m_ready_from = cyc + 1;
      end
    end
    if (MemWrEn && (MemWrAddr[31:2] < 30'd1024)) mem_model[MemWrAddr[11:2]] = MemWrData;
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    #1;
    m_busy = 1'b0;
    check("rst_req_ready", FillReqReady, 0);
    check("rst_rsp_valid", FillRspValid, 0);
    check("rst_rsp_err", FillRspErr, 0);
    check("rst_rsp_addr", FillRspAddr, 0);
    check("rst_rsp_data", FillRspData, 0);
    step();
    step();
    Rst = 1'b0;
    m_ready_from = cyc + 1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!FillReqReady && n < 50) begin
      step();
      n++;
    end
    if (!FillReqReady) check("wait_ready_timeout", 0, 1);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!FillRspValid && n < 20) begin
      step();
      n++;
    end
    if (!FillRspValid) check("wait_valid_timeout", 0, 1);
  endtask

  // Issue one request and stop in the first cycle its response is visible.
  task automatic request(input logic [27:0] a, output int lat);
    int t;
    wait_ready();
    FillReqValid = 1'b1;
    FillReqAddr  = a;
    step();
    FillReqValid = 1'b0;
    t = cyc - 1;
    wait_valid();
    lat = cyc - t;
  endtask

  task automatic write_word(input logic [31:0] baddr, input logic [31:0] data);
    MemWrEn   = 1'b1;
    MemWrAddr = baddr;
    MemWrData = data;
    step();
    MemWrEn   = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] line5;
    logic [127:0] line_obs;
    int           lat;
    int           h;
    int           r;

    line5 = 128'h44444444_33333333_22222222_11111111;
    n_chk = 0;
    n_err = 0;
    cyc   = 0;
    m_busy = 1'b0;
    m_err  = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_t = 0;
    m_rsp_cycle = 0;
    m_ready_from = 0;
    Rst = 1'b1;
    FillReqValid = 1'b0;
    FillReqAddr  = '0;
    FillRspReady = 1'b0;
    MemWrEn      = 1'b0;
    MemWrAddr    = '0;
    MemWrData    = '0;
    repeat (2) @(posedge Clk);
    #1;
    do_reset();

    // Fill the whole store, then the lines used by directed tests.
    for (int i = 0; i < 1024; i++) write_word(32'(i * 4), $urandom);
    for (int k = 0; k < 4; k++) write_word(32'h50 + 32'(k * 4), 32'h11111111 * (k + 1));
    for (int k = 0; k < 4; k++) write_word(32'h20 + 32'(k * 4), 32'hA2A2A2A0 + 32'(k));

    // In-range fill latency and data
    FillRspReady = 1'b1;
    request(28'h5, lat);
    check("fill5_latency", lat, 6);
    check("fill5_data", FillRspData, line5);
    check("fill5_addr", FillRspAddr, 28'h5);
    check("fill5_err", FillRspErr, 0);
    step();

    // Out-of-range request
    request(28'h100, lat);
    check("oor_latency", lat, 1);
    check("oor_err", FillRspErr, 1);
    check("oor_data", FillRspData, 0);
    check("oor_addr", FillRspAddr, 28'h100);
    step();

    // Response held under back-pressure
    FillRspReady = 1'b0;
    request(28'h5, lat);
    check("hold_latency", lat, 6);
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_data", FillRspData, line5);
      check("hold_addr", FillRspAddr, 28'h5);
      check("hold_req_ready", FillReqReady, 0);
    end
    FillRspReady = 1'b1;
    step();
    check("release_req_ready", FillReqReady, 1);

    // Write word3 of line 2 in the cycle it is read
    wait_ready();
    FillReqValid = 1'b1;
    FillReqAddr  = 28'h2;
    step();
    FillReqValid = 1'b0;
    repeat (3) step();
    write_word(32'h2C, 32'hDEADBEEF);
    wait_valid();
    line_obs = FillRspData;
    check("rbw_word3_old", line_obs[127:96], 32'hA2A2A2A3);
    check("rbw_word0", line_obs[31:0], 32'hA2A2A2A0);
    step();
    request(28'h2, lat);
    line_obs = FillRspData;
    check("rbw_word3_new", line_obs[127:96], 32'hDEADBEEF);
    step();

    // Reset in the middle of a READ aborts the request
    wait_ready();
    FillReqValid = 1'b1;
    FillReqAddr  = 28'h5;
    step();
    FillReqValid = 1'b0;
    step();
    step();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      check("abort_no_valid", FillRspValid, 0);
      step();
    end
    request(28'h5, lat);
    check("post_rst_latency", lat, 6);
    check("post_rst_data", FillRspData, line5);
    step();

    // Back-to-back requests with FillReqValid held high
    wait_ready();
    FillReqValid = 1'b1;
    FillReqAddr  = 28'h1;
    step();
    FillReqAddr  = 28'h2;
    wait_valid();
    check("b2b_first_addr", FillRspAddr, 28'h1);
    h = cyc;
    step();
    check("b2b_req_ready", FillReqReady, 1);
    step();
    FillReqValid = 1'b0;
    wait_valid();
    check("b2b_second_addr", FillRspAddr, 28'h2);
    check("b2b_second_gap", cyc - h, 7);
    step();

    // Out-of-range write must not alias onto word 5 (line 1, word 1)
    write_word(32'h0000_1014, 32'hBADBAD00);
    request(28'h1, lat);
    line_obs = FillRspData;
    check("oob_write_dropped", line_obs[63:32], mem_model[5]);
    step();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      FillReqValid = ($urandom_range(0, 2) == 0);
      r = int'($urandom_range(0, 15));
      if (r == 0)      FillReqAddr = 28'($urandom);
      else if (r == 1) FillReqAddr = 28'(256 + $urandom_range(0, 255));
      else             FillReqAddr = 28'($urandom_range(0, 255));
      FillRspReady = ($urandom_range(0, 1) == 1);
      MemWrEn      = ($urandom_range(0, 3) == 0);
      r = int'($urandom_range(0, 7));
      if (r == 0)      MemWrAddr = $urandom;
      else if (r == 1) MemWrAddr = 32'(4096 + $urandom_range(0, 4095));
      else             MemWrAddr = 32'($urandom_range(0, 4095));
      MemWrData = $urandom;
      step();
    end
    FillReqValid = 1'b0;
    MemWrEn      = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
